mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its control and data outputs.
- Drives a request/acknowledge data-memory port with variable latency, and stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register that feeds write-back.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort; used only with DMEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control from EX/MEM.
- ALUout_i  in  32  ALU result; used as the memory address for loads and stores.
- rs2_data_i  in  32  store data.
- rd_addr_i  in  5  destination register.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write, 0 = read.
- dmem_addr_o  out  ADDR_W  word-aligned address, {ALUout_i[31:2],2'b00}.
- dmem_wdata_o  out  DATA_W  equals rs2_data_i.
- dmem_ack_i  in  1  access complete; sampled only while dmem_req_o=1.
- dmem_rdata_i  in  DATA_W  read data, valid with dmem_ack_i on reads.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control.
- ALUout_o  out  32  MEM/WB ALU result.
- mem_data_o  out  32  MEM/WB load data.
- rd_addr_o  out  5  MEM/WB destination register.
- dmem_err_o  out  1  one-cycle timeout pulse; only with DMEM_TIMEOUT_EN.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State is IDLE and the read buffer is 0.
  - All MEM/WB outputs are 0; dmem_req_o=0; dmem_err_o=0.
  - Upstream EX/MEM content is not this block's concern.
- Memory op: mem_op = MemRead_i | MemWrite_i. If both are set, it is a write.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with mem_op:
    - dmem_req_o=1, dmem_we_o=MemWrite_i, stall_o=1.
    - With dmem_ack_i: capture dmem_rdata_i into the buffer (reads only) and go to DONE.
    - Without dmem_ack_i: go to BUSY.
  - IDLE without mem_op: dmem_req_o=0, stall_o=0, stay in IDLE.
  - BUSY: dmem_req_o=1, stall_o=1. Address, we and wdata stay stable because upstream is frozen. On dmem_ack_i: capture the buffer and go to DONE.
  - DONE: dmem_req_o=0, stall_o=0. MEM/WB captures the instruction with mem_data_o = buffer. Next state is IDLE.
    - A new mem_op arriving in the IDLE cycle that follows starts a fresh access.
- MEM/WB register update, every rising edge:
  - When stall_o=0: capture RegWrite_i, MemtoReg_i, ALUout_i and rd_addr_i. mem_data_o takes the buffer in DONE, otherwise 0.
  - When stall_o=1: insert a bubble. RegWrite_o=0, MemtoReg_o=0, rd_addr_o=0; ALUout_o and mem_data_o hold their values.
- Latency:
  - Non-memory instruction: 1 cycle, no stall.
  - Memory op with ack after k request cycles (k>=1): k+1 cycles in the stage; upstream is stalled k cycles.
- Ack outside a request (dmem_req_o=0): ignored.
- Store: mem_data_o=0. RegWrite_o comes from RegWrite_i as passed.
- Reset mid-BUSY: the request drops immediately. The memory side must tolerate an abandoned request.
- stall_o and dmem_req_o are combinational from the state and the inputs. All MEM/WB outputs are registered.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit (or wider, sized by TIMEOUT_CYCLES) counter clears on entering BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES without ack, the block goes to DONE with buffer=0 and pulses dmem_err_o for 1 cycle.
- Undefined:
  - No counter is present; BUSY waits indefinitely.
  - dmem_err_o is tied to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - ADDR_W / DATA_W defaults;
  - REG_ADDR_W=5.
- Sub-module mem_wb_reg: MEM/WB flops with capture and bubble inputs and asynchronous active-low reset. The FSM and handshake stay in the top module.

Test Plan:
- ALU instruction (RegWrite_i=1, ALUout_i=0x0000_0010, rd=5), no mem op -> stall_o stays 0; next edge ALUout_o=0x10, rd_addr_o=5, RegWrite_o=1.
- Load at ALUout_i=0x0000_0104, ack in same cycle with rdata 0xDEAD_BEEF -> dmem_addr_o=0x104, stall 1 cycle, then mem_data_o=0xDEAD_BEEF, MemtoReg_o=1.
- Store rs2=0x1234_5678 at 0x200, ack after 3 request cycles -> dmem_we_o=1 and wdata stable for 3 cycles; bubbles (RegWrite_o=0) during the stall; 3 stall cycles.
- Back-to-back load/load, each ack at cycle 2 -> two distinct requests separated by one DONE cycle; both load values appear on mem_data_o in order.
- Reset asserted mid-BUSY -> dmem_req_o and all outputs go to 0 asynchronously; after release, state is IDLE.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> dmem_err_o pulses once after 4 BUSY cycles, mem_data_o=0, stall releases.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage.
// State codes are plain localparams so legacy tooling can decode them.
package mem_stage_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on capture, squashes control on bubble,
// otherwise holds.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int unsigned ALU_W  = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  capture_i,
    input  logic                  bubble_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic [ALU_W-1:0]      alu_out_i,
    input  logic [DATA_W-1:0]     mem_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic [ALU_W-1:0]      alu_out_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            alu_out_o    <= '0;
            mem_data_o   <= '0;
            rd_addr_o    <= '0;
        end else if (capture_i) begin
            reg_write_o  <= reg_write_i;
            mem_to_reg_o <= mem_to_reg_i;
            alu_out_o    <= alu_out_i;
            mem_data_o   <= mem_data_i;
            rd_addr_o    <= rd_addr_i;
        end else if (bubble_i) begin
            // Data fields hold; only the write-enabling fields are squashed.
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            rd_addr_o    <= '0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: variable-latency data-memory handshake with upstream stall and
// the MEM/WB register. Define DMEM_TIMEOUT_EN to abort accesses stuck in BUSY.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [31:0]           ALUout_i,
    input  logic [DATA_W-1:0]     rs2_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_W-1:0]     dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  stall_o,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic [31:0]           ALUout_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  dmem_err_o
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              mem_op;
    logic              req;
    logic              timeout;
    logic [DATA_W-1:0] wb_mem_data;

    assign mem_op = MemRead_i | MemWrite_i;

    // Gated by reset so an abandoned request drops the moment reset asserts.
    assign req = rst_i & (((state_q == IDLE) & mem_op) | (state_q == BUSY));

    assign dmem_req_o   = req;
    assign stall_o      = req;
    assign dmem_we_o    = MemWrite_i;
    assign dmem_addr_o  = {ALUout_i[ADDR_W-1:2], 2'b00};
    assign dmem_wdata_o = rs2_data_i;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    // Counter is zero on BUSY entry, so the last allowed cycle sees TIMEOUT_CYCLES-1.
    assign timeout = (state_q == BUSY) & ~dmem_ack_i &
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == BUSY) ? cnt_q + 1'b1 : '0;
            err_q <= timeout;
        end
    end

    assign dmem_err_o = err_q;
`else
    assign timeout    = 1'b0;
    assign dmem_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (dmem_ack_i) begin
                        state_d = DONE;
                        buf_d   = MemWrite_i ? '0 : dmem_rdata_i;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack_i) begin
                    state_d = DONE;
                    buf_d   = MemWrite_i ? '0 : dmem_rdata_i;
                end else if (timeout) begin
                    state_d = DONE;
                    buf_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    assign wb_mem_data = (state_q == DONE) ? buf_q : '0;

    mem_wb_reg #(
        .ALU_W  (32),
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .capture_i    (~stall_o),
        .bubble_i     (stall_o),
        .reg_write_i  (RegWrite_i),
        .mem_to_reg_i (MemtoReg_i),
        .alu_out_i    (ALUout_i),
        .mem_data_i   (wb_mem_data),
        .rd_addr_i    (rd_addr_i),
        .reg_write_o  (RegWrite_o),
        .mem_to_reg_o (MemtoReg_o),
        .alu_out_o    (ALUout_o),
        .mem_data_o   (mem_data_o),
        .rd_addr_o    (rd_addr_o)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage; models each instruction as
// "k request cycles, one DONE cycle, then a MEM/WB write".
module tb_mem_access_stage;

    localparam int unsigned TO_CYCLES = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUout_i, rs2_data_i, dmem_rdata_i;
    logic [4:0]  rd_addr_i;
    logic        dmem_ack_i;
    logic        dmem_req_o, dmem_we_o, stall_o, dmem_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, ALUout_o, mem_data_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [4:0]  rd_addr_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_alu  = '0;
    logic [31:0] exp_mem  = '0;

    mem_access_stage #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .RegWrite_i   (RegWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .ALUout_i     (ALUout_i),
        .rs2_data_i   (rs2_data_i),
        .rd_addr_i    (rd_addr_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .stall_o      (stall_o),
        .RegWrite_o   (RegWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .ALUout_o     (ALUout_o),
        .mem_data_o   (mem_data_o),
        .rd_addr_o    (rd_addr_o),
        .dmem_err_o   (dmem_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_inputs();
        RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
        ALUout_i = '0; rs2_data_i = '0; rd_addr_i = '0;
        dmem_ack_i = 0; dmem_rdata_i = '0;
    endtask

    // Runs one instruction from a negedge with the stage idle; returns at a negedge.
    // k = number of request cycles until ack (ignored for non-memory ops).
    task automatic do_instr(input string name, input bit rw, input bit m2r, input bit rd_en,
                            input bit wr_en, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [4:0] rd, input int k, input logic [31:0] rdata,
                            input bit stray_ack);
        bit          memop;
        logic [31:0] waddr;
        memop = rd_en | wr_en;
        waddr = {alu[31:2], 2'b00};
        RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = rd_en; MemWrite_i = wr_en;
        ALUout_i = alu; rs2_data_i = rs2; rd_addr_i = rd;
        if (memop) begin
            for (int i = 1; i <= k; i++) begin
                dmem_ack_i   = (i == k);
                dmem_rdata_i = (i == k) ? rdata : $urandom;
                #1;
                n_checks++;
                if ({dmem_req_o, stall_o, dmem_we_o, dmem_addr_o, dmem_wdata_o} !==
                    {1'b1, 1'b1, wr_en, waddr, rs2}) begin
                    n_fail++;
                    $display("FAIL %s req cyc %0d: got req/stall/we/addr/wdata %b%b%b %h %h expected 111/%b %h %h",
                             name, i, dmem_req_o, stall_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
                             wr_en, waddr, rs2);
                end
                @(negedge clk_i);
                n_checks++;
                if ({RegWrite_o, MemtoReg_o, rd_addr_o, ALUout_o, mem_data_o} !==
                    {1'b0, 1'b0, 5'd0, exp_alu, exp_mem}) begin
                    n_fail++;
                    $display("FAIL %s bubble %0d: got rw/m2r/rd/alu/mem %b %b %0d %h %h expected 0 0 0 %h %h",
                             name, i, RegWrite_o, MemtoReg_o, rd_addr_o, ALUout_o, mem_data_o,
                             exp_alu, exp_mem);
                end
            end
        end
        // DONE cycle for memory ops, the only cycle for others; ack here must be ignored.
        dmem_ack_i   = stray_ack;
        dmem_rdata_i = $urandom;
        #1;
        n_checks++;
        if ({dmem_req_o, stall_o, dmem_err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s release: got req/stall/err %b%b%b expected 000",
                     name, dmem_req_o, stall_o, dmem_err_o);
        end
        @(negedge clk_i);
        exp_alu = alu;
        exp_mem = (memop && !wr_en) ? rdata : 32'h0;
        n_checks++;
        if ({RegWrite_o, MemtoReg_o, rd_addr_o, ALUout_o, mem_data_o} !==
            {rw, m2r, rd, exp_alu, exp_mem}) begin
            n_fail++;
            $display("FAIL %s writeback: got rw/m2r/rd/alu/mem %b %b %0d %h %h expected %b %b %0d %h %h",
                     name, RegWrite_o, MemtoReg_o, rd_addr_o, ALUout_o, mem_data_o,
                     rw, m2r, rd, exp_alu, exp_mem);
        end
        dmem_ack_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 0;
        MemRead_i = 1; RegWrite_i = 1; ALUout_i = 32'hFFFF_FFFF; rd_addr_i = 5'd31;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_checks++;
            if ({dmem_req_o, stall_o, dmem_err_o, RegWrite_o, MemtoReg_o, rd_addr_o,
                 ALUout_o, mem_data_o} !== '0) begin
                n_fail++;
                $display("FAIL reset: got req/stall/err/rw/m2r %b%b%b%b%b rd %0d alu %h mem %h expected all 0",
                         dmem_req_o, stall_o, dmem_err_o, RegWrite_o, MemtoReg_o, rd_addr_o,
                         ALUout_o, mem_data_o);
            end
        end
        clear_inputs();
        rst_i   = 1;
        exp_alu = '0;
        exp_mem = '0;
    endtask

    task automatic test_alu();
        do_instr("alu", 1, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0, 0);
    endtask

    task automatic test_load_same_cycle();
        do_instr("load_k1", 1, 1, 1, 0, 32'h0000_0104, 32'h0, 5'd7, 1, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_store_wait();
        do_instr("store_k3", 0, 0, 0, 1, 32'h0000_0200, 32'h1234_5678, 5'd0, 3, 32'hAAAA_5555, 0);
        do_instr("store_unaligned", 1, 0, 0, 1, 32'h0000_0203, 32'hCAFE_F00D, 5'd9, 2,
                 32'h1111_2222, 1);
    endtask

    task automatic test_back_to_back();
        do_instr("b2b_load0", 1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd10, 2, 32'h0BAD_F00D, 0);
        do_instr("b2b_load1", 1, 1, 1, 0, 32'h0000_0304, 32'h0, 5'd11, 2, 32'h1357_9BDF, 0);
    endtask

    task automatic test_stray_ack();
        do_instr("stray_ack", 1, 0, 0, 0, 32'h0000_0ABC, 32'h0, 5'd3, 0, 32'hFFFF_FFFF, 1);
        do_instr("read_write", 1, 0, 1, 1, 32'h0000_0400, 32'h5A5A_A5A5, 5'd4, 1,
                 32'h7777_7777, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int unsigned op;
            op = $urandom_range(0, 3);
            do_instr("random", 1'($urandom), 1'($urandom), op == 1 || op == 3, op >= 2,
                     $urandom, $urandom, 5'($urandom), int'($urandom_range(1, 4)), $urandom,
                     1'($urandom));
        end
    endtask

    task automatic test_reset_mid_busy();
        RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
        ALUout_i = 32'h0000_0500; rd_addr_i = 5'd12; dmem_ack_i = 0;
        @(negedge clk_i);
        #1;
        n_checks++;
        if (dmem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_reset: got req %b expected 1", dmem_req_o);
        end
        rst_i = 0;
        #1;
        n_checks++;
        if ({dmem_req_o, stall_o, dmem_err_o, RegWrite_o, MemtoReg_o, rd_addr_o,
             ALUout_o, mem_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got req/stall/err/rw/m2r %b%b%b%b%b rd %0d alu %h mem %h expected all 0",
                     dmem_req_o, stall_o, dmem_err_o, RegWrite_o, MemtoReg_o, rd_addr_o,
                     ALUout_o, mem_data_o);
        end
        @(negedge clk_i);
        clear_inputs();
        rst_i   = 1;
        exp_alu = '0;
        exp_mem = '0;
        @(negedge clk_i);
        #1;
        n_checks++;
        if ({dmem_req_o, stall_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got req/stall %b%b expected 00", dmem_req_o, stall_o);
        end
        @(negedge clk_i);
        do_instr("load_after_reset", 1, 1, 1, 0, 32'h0000_0600, 32'h0, 5'd13, 1,
                 32'h2468_ACE0, 0);
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n = 0;
        RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
        ALUout_i = 32'h0000_0700; rd_addr_i = 5'd14; dmem_ack_i = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (!stall_o) break;
            n++;
            @(negedge clk_i);
        end
        n_checks++;
        if (n != 1 + TO_CYCLES) begin
            n_fail++;
            $display("FAIL timeout_stall: got %0d stall cycles expected %0d", n, 1 + TO_CYCLES);
        end
        n_checks++;
        if (dmem_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err_pulse: got %b expected 1", dmem_err_o);
        end
        @(negedge clk_i);
        exp_alu = 32'h0000_0700;
        exp_mem = '0;
        n_checks++;
        if ({dmem_err_o, RegWrite_o, rd_addr_o, ALUout_o, mem_data_o} !==
            {1'b0, 1'b1, 5'd14, exp_alu, exp_mem}) begin
            n_fail++;
            $display("FAIL timeout_wb: got err/rw/rd/alu/mem %b %b %0d %h %h expected 0 1 14 %h 0",
                     dmem_err_o, RegWrite_o, rd_addr_o, ALUout_o, mem_data_o, exp_alu);
        end
        clear_inputs();
        @(negedge clk_i);
    endtask
`endif

    initial begin
        clear_inputs();
        rst_i = 0;
        test_reset();
        test_alu();
        test_load_same_cycle();
        test_store_wait();
        test_back_to_back();
        test_stray_ack();
        test_random();
        test_reset_mid_busy();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
